// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller driving an R2R ladder
// Optional feature macro: SAR_ADC_AVG_EN (four conversions averaged per start)
module sar_adc_ctrl #(
    parameter int SETTLE_CYCLES = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmp_in,
    output logic [7:0] dac_code,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       valid
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    // The sync latency plus the decide cycle must fit inside the settle window.
    if (SETTLE_CYCLES < 4) begin : g_settle_chk
        $error("sar_adc_ctrl: SETTLE_CYCLES must be >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t        r_state, w_state;
    logic          r_cmp_meta;
    logic          r_cmp_s;
    logic [CW-1:0] r_cnt, w_cnt;
    logic [2:0]    r_idx, w_idx;
    logic [7:0]    r_dac, w_dac;
    logic [7:0]    r_result, w_result;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_valid, w_valid;
    logic [7:0]    w_code_dec;

`ifdef SAR_ADC_AVG_EN
    logic [9:0]    r_acc, w_acc;
    logic [1:0]    r_conv, w_conv;
    logic [9:0]    w_sum;
`endif

    // Trial code after the current bit has been resolved by the comparator.
    assign w_code_dec = r_cmp_s ? r_dac : (r_dac & ~(8'h01 << r_idx));

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmp_meta <= 1'b0;
            r_cmp_s    <= 1'b0;
        end else begin
            r_cmp_meta <= cmp_in;
            r_cmp_s    <= r_cmp_meta;
        end
    end

    // State and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_dac    <= 8'h00;
            r_result <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_valid  <= 1'b0;
`ifdef SAR_ADC_AVG_EN
            r_acc    <= 10'd0;
            r_conv   <= 2'd0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_dac    <= w_dac;
            r_result <= w_result;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_valid  <= w_valid;
`ifdef SAR_ADC_AVG_EN
            r_acc    <= w_acc;
            r_conv   <= w_conv;
`endif
        end
    end

    // Next-state and next-datapath logic for the SAR sequence.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_dac    = r_dac;
        w_result = r_result;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_valid  = r_valid;
`ifdef SAR_ADC_AVG_EN
        w_acc    = r_acc;
        w_conv   = r_conv;
        w_sum    = r_acc + {2'b00, w_code_dec};
`endif
        case (r_state)
            S_IDLE: begin
                w_dac = r_result;
                if (start) begin
                    w_state = S_SETTLE;
                    w_idx   = 3'd7;
                    w_dac   = 8'h80;
                    w_cnt   = '0;
                    w_busy  = 1'b1;
`ifdef SAR_ADC_AVG_EN
                    w_acc   = 10'd0;
                    w_conv  = 2'd0;
`endif
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state = S_DECIDE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DECIDE: begin
                if (r_idx != 3'd0) begin
                    w_dac   = w_code_dec | (8'h01 << (r_idx - 3'd1));
                    w_idx   = r_idx - 3'd1;
                    w_cnt   = '0;
                    w_state = S_SETTLE;
                end else begin
`ifdef SAR_ADC_AVG_EN
                    if (r_conv != 2'd3) begin
                        // Chain straight into the next conversion of the set.
                        w_acc   = w_sum;
                        w_conv  = r_conv + 2'd1;
                        w_dac   = 8'h80;
                        w_idx   = 3'd7;
                        w_cnt   = '0;
                        w_state = S_SETTLE;
                    end else begin
                        w_result = 8'(w_sum >> 2);
                        w_dac    = 8'(w_sum >> 2);
                        w_done   = 1'b1;
                        w_valid  = 1'b1;
                        w_busy   = 1'b0;
                        w_state  = S_DONE;
                    end
`else
                    w_result = w_code_dec;
                    w_dac    = w_code_dec;
                    w_done   = 1'b1;
                    w_valid  = 1'b1;
                    w_busy   = 1'b0;
                    w_state  = S_DONE;
`endif
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign dac_code = r_dac;
    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign valid    = r_valid;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl with an ideal comparator model
module tb_sar_adc_ctrl;

    localparam int S = 4;
`ifdef SAR_ADC_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif
    localparam int CONV_CYC = 8 * (S + 1);
    localparam int LAT      = NCONV * CONV_CYC + 1;
    localparam int PERIOD   = NCONV * CONV_CYC + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] vin = 8'h00;
    logic       cmp_in;
    logic [7:0] dac_code;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       valid;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic [7:0] obs[8];
    logic [7:0] a5_seq[8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    typedef struct {
        logic [7:0] v0, v1, v2, v3;
        bit         extra;
        logic [7:0] exp_res;
    } vec_t;

    vec_t tbl[7];

    sar_adc_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp_in   (cmp_in),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .valid    (valid)
    );

    // Ideal comparator with zero delay.
    assign cmp_in = (vin >= dac_code);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Trial code presented at step k of a binary search for v.
    function automatic logic [7:0] trial_at(input logic [7:0] v, input int k);
        int code, t;
        code = 0;
        t    = 0;
        for (int j = 0; j <= k; j++) begin
            t = code + (128 >> j);
            if (j < k && int'(v) >= t) code = t;
        end
        return 8'(t);
    endfunction

    // An ideal SAR returns vin; averaging mode returns floor of the mean.
    function automatic logic [7:0] model_result(input logic [7:0] v0, v1, v2, v3);
        if (NCONV == 4) return 8'((int'(v0) + int'(v1) + int'(v2) + int'(v3)) >> 2);
        return v0;
    endfunction

    task automatic run_conv(input logic [7:0] v0, v1, v2, v3, input bit extra,
                            input logic [7:0] exp_res, input string tag);
        logic [7:0] vv[4];
        int c_pre, n, ndone, done_n, busy_bad, dac_bad, c, k;
        vv[0] = v0; vv[1] = v1; vv[2] = v2; vv[3] = v3;
        ndone = 0; done_n = -1; busy_bad = 0; dac_bad = 0;
        @(negedge clk);
        vin   = vv[0];
        start = 1'b1;
        c_pre = cyc;
        for (int i = 0; i < LAT + 40; i++) begin
            @(negedge clk);
            n = cyc - c_pre;
            start = extra && (n == 10 || n == 30 || n == LAT);
            if (n >= 1 && n < LAT) begin
                c = (n - 1) / CONV_CYC;
                k = ((n - 1) % CONV_CYC) / (S + 1);
                if ((n - 1) % CONV_CYC == 0) vin = vv[c];
                if ((n - 1) % (S + 1) == 1) begin
                    if (c == 0) obs[k] = dac_code;
                    if (dac_code != trial_at(vv[c], k)) dac_bad++;
                end
                if (!busy) busy_bad++;
            end
            if (n == LAT && busy) busy_bad++;
            if (done) begin
                ndone++;
                if (done_n < 0) done_n = n;
            end
        end
        start = 1'b0;
        chk({tag, "_done_edge"}, done_n, LAT);
        chk({tag, "_done_count"}, ndone, 1);
        chk({tag, "_result"}, int'(result), int'(exp_res));
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_trial_errs"}, dac_bad, 0);
        chk({tag, "_busy_errs"}, busy_bad, 0);
        chk({tag, "_idle_dac"}, int'(dac_code), int'(exp_res));
    endtask

    initial begin
        int c_pre, n, ndone;
        int dq[$];
        logic [7:0] r0, r1, r2, r3;

        tbl[0] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 8'hA5};
        tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF};
        tbl[3] = '{8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 8'h80};
        tbl[4] = '{8'h01, 8'h01, 8'h01, 8'h01, 1'b1, 8'h01};
        tbl[5] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1, 8'h7F};
`ifdef SAR_ADC_AVG_EN
        tbl[6] = '{8'h40, 8'h42, 8'h40, 8'h42, 1'b0, 8'h41};
`else
        tbl[6] = '{8'h40, 8'h42, 8'h40, 8'h42, 1'b0, 8'h40};
`endif

        // Reset state, during and after reset.
        #1;
        chk("reset_outputs", int'({dac_code, result, busy, done, valid}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_outputs", int'({dac_code, result, busy, done, valid}), 0);

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_conv(tbl[i].v0, tbl[i].v1, tbl[i].v2, tbl[i].v3, tbl[i].extra,
                     tbl[i].exp_res, $sformatf("vec%0d", i));
            if (i == 0) begin
                for (int k = 0; k < 8; k++)
                    chk($sformatf("a5_trial%0d", k), int'(obs[k]), int'(a5_seq[k]));
            end
        end

        // Start held high: back-to-back conversions.
        @(negedge clk);
        vin   = 8'h5A;
        start = 1'b1;
        c_pre = cyc;
        for (int i = 0; i < 3 * PERIOD + 5; i++) begin
            @(negedge clk);
            if (done) dq.push_back(cyc - c_pre);
        end
        start = 1'b0;
        repeat (PERIOD + 5) @(negedge clk);
        chk("held_done_count_ge3", int'(dq.size() >= 3), 1);
        chk("held_first_done", dq.size() > 0 ? dq[0] : -1, LAT);
        chk("held_period_1", dq.size() > 1 ? dq[1] - dq[0] : -1, PERIOD);
        chk("held_period_2", dq.size() > 2 ? dq[2] - dq[1] : -1, PERIOD);
        chk("held_result", int'(result), int'(model_result(8'h5A, 8'h5A, 8'h5A, 8'h5A)));

        // Abort during bit-3 settle, then a clean conversion.
        @(negedge clk);
        vin   = 8'hC3;
        start = 1'b1;
        c_pre = cyc;
        n     = 0;
        for (int i = 0; i < LAT && n < 22; i++) begin
            @(negedge clk);
            n = cyc - c_pre;
            if (n >= 1) start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        chk("abort_reset_outputs", int'({dac_code, result, busy, done, valid}), 0);
        ndone = 0;
        repeat (3) @(negedge clk) ndone += int'(done);
        rst = 1'b1;
        repeat (LAT + 4) @(negedge clk) ndone += int'(done);
        chk("abort_no_done", ndone, 0);
        chk("abort_held_outputs", int'({dac_code, result, busy, done, valid}), 0);
        run_conv(8'h3C, 8'h3C, 8'h3C, 8'h3C, 1'b0, 8'h3C, "after_abort");

        // Random codes against the reference model.
        for (int i = 0; i < 6; i++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            r3 = 8'($urandom_range(0, 255));
            run_conv(r0, r1, r2, r3, 1'($urandom_range(0, 1)),
                     model_result(r0, r1, r2, r3), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
